// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   hz_action_e  : action chosen by the controller each cycle
//   sb_cnt_w()   : width of a scoreboard countdown for a given load latency
//   LOAD_LAT_MIN / LOAD_LAT_MAX : supported load-latency range (1..7)
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 7;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_FLUSH,
    HZ_FREEZE
  } hz_action_e;

  // A countdown must hold values 0..LOAD_LAT-1; clog2(LOAD_LAT+1) also keeps
  // LOAD_LAT=1 at a legal one-bit width.
  function automatic int unsigned sb_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
// Per-register countdown of outstanding load results. A load issuing to rd
// reloads count[rd] to LOAD_LAT-1; every other nonzero count decays by one
// per edge unless the pipeline is frozen. Two lookup ports report whether a
// register still has a pending load result.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_issue, i_issue_rd   load issuing this edge and its destination
//   i_hold                freeze: no issue, no decay
//   i_lkp_a, i_lkp_b      lookup register indices
//   o_busy_a, o_busy_b    lookup register has a nonzero countdown
// -----------------------------------------------------------------------------
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_hold,
  input  logic [REG_ADDR_W-1:0] i_lkp_a,
  input  logic [REG_ADDR_W-1:0] i_lkp_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = int'(sb_cnt_w(LOAD_LAT));
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_count [NUM_REGS];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the count array is a bank of flops, not a RAM, and is reset
  // explicitly so a reset in the middle of a stall drops every pending load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
    end else if (!i_hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_issue && (i_issue_rd == REG_ADDR_W'(i))) begin
          r_count[i] <= CNT_RELOAD;      // issue wins over decay
        end else if (r_count[i] != '0) begin
          r_count[i] <= r_count[i] - CNT_ONE;
        end
      end
    end
  end

  assign o_busy_a = (r_count[i_lkp_a] != '0);
  assign o_busy_b = (r_count[i_lkp_b] != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard controller for the 5-stage core. Detects load-use hazards against
// the load in EX and against older loads still tracked in the scoreboard,
// flushes IF/ID on a taken branch and freezes the pipe while data memory is
// busy. Priority: freeze > flush > load-use stall > none.
// Optional feature macro: HAZARD_PERF_CNT_EN enables saturating stall/flush
// counters; without it both counter outputs are tied to zero.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_id_ex_mem_read, i_id_ex_rd      load in EX and its destination
//   i_if_id_rs/_rt, *_used            sources of the instruction in ID
//   i_ex_branch_taken                 taken branch/jump resolved in EX
//   i_dmem_busy                       data memory not ready
//   o_pc_write_enable                 0 = hold PC
//   o_if_id_pipe_enable               0 = hold IF/ID
//   o_id_ex_pipe_enable               0 = hold ID/EX
//   o_if_id_flush                     1 = load NOP into IF/ID
//   o_exe_ctrl_mux_ctrl               0 = bubble into ID/EX control
//   o_stall_cycles, o_flush_count     performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_if_id_rs,
  input  logic [REG_ADDR_W-1:0] i_if_id_rt,
  input  logic                  i_if_id_rs_used,
  input  logic                  i_if_id_rt_used,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_dmem_busy,
  output logic                  o_pc_write_enable,
  output logic                  o_if_id_pipe_enable,
  output logic                  o_id_ex_pipe_enable,
  output logic                  o_if_id_flush,
  output logic                  o_exe_ctrl_mux_ctrl,
  output logic [PERF_CNT_W-1:0] o_stall_cycles,
  output logic [PERF_CNT_W-1:0] o_flush_count
);

  logic       w_issue;
  logic       w_sb_busy_rs;
  logic       w_sb_busy_rt;
  logic       w_hit_rs;
  logic       w_hit_rt;
  logic       w_load_use;
  hz_action_e w_action;

  // A squashed or frozen load never reaches MEM this edge, so it must not
  // start a countdown.
  assign w_issue = i_id_ex_mem_read && (i_id_ex_rd != '0) &&
                   !i_dmem_busy && !i_ex_branch_taken;

  load_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) u_load_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_issue    (w_issue),
    .i_issue_rd (i_id_ex_rd),
    .i_hold     (i_dmem_busy),
    .i_lkp_a    (i_if_id_rs),
    .i_lkp_b    (i_if_id_rt),
    .o_busy_a   (w_sb_busy_rs),
    .o_busy_b   (w_sb_busy_rt)
  );

  // The load still in EX is not yet in the scoreboard, so match it directly.
  assign w_hit_rs = i_if_id_rs_used && (i_if_id_rs != '0) &&
                    ((i_id_ex_mem_read && (i_id_ex_rd == i_if_id_rs)) || w_sb_busy_rs);
  assign w_hit_rt = i_if_id_rt_used && (i_if_id_rt != '0) &&
                    ((i_id_ex_mem_read && (i_id_ex_rd == i_if_id_rt)) || w_sb_busy_rt);
  assign w_load_use = w_hit_rs || w_hit_rt;

  // NOTE: every combinational output gets a default before the decision
  // logic so no path leaves a value unassigned and infers a latch.
  always_comb begin
    w_action = HZ_NONE;
    if (i_rst)                  w_action = HZ_NONE;
    else if (i_dmem_busy)       w_action = HZ_FREEZE;
    else if (i_ex_branch_taken) w_action = HZ_FLUSH;
    else if (w_load_use)        w_action = HZ_LOAD_USE;
  end

  always_comb begin
    o_pc_write_enable   = 1'b1;
    o_if_id_pipe_enable = 1'b1;
    o_id_ex_pipe_enable = 1'b1;
    o_if_id_flush       = 1'b0;
    o_exe_ctrl_mux_ctrl = 1'b1;
    unique case (w_action)
      HZ_FREEZE: begin
        o_pc_write_enable   = 1'b0;
        o_if_id_pipe_enable = 1'b0;
        o_id_ex_pipe_enable = 1'b0;
      end
      HZ_FLUSH: begin
        o_if_id_flush       = 1'b1;
        o_exe_ctrl_mux_ctrl = 1'b0;
      end
      HZ_LOAD_USE: begin
        o_pc_write_enable   = 1'b0;
        o_if_id_pipe_enable = 1'b0;
        o_exe_ctrl_mux_ctrl = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] PERF_MAX = '1;
  localparam logic [PERF_CNT_W-1:0] PERF_ONE = PERF_CNT_W'(1);

  logic [PERF_CNT_W-1:0] r_stall_cycles;
  logic [PERF_CNT_W-1:0] r_flush_count;

  // Counters saturate rather than wrap so a long run never under-reports.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((w_action == HZ_LOAD_USE) && (r_stall_cycles != PERF_MAX))
        r_stall_cycles <= r_stall_cycles + PERF_ONE;
      if ((w_action == HZ_FLUSH) && (r_flush_count != PERF_MAX))
        r_flush_count <= r_flush_count + PERF_ONE;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule
